// File: rtl/mot_update_sched.sv
// Periodic four-motor setpoint scheduler: each tick computes per-motor targets from
// the latched altitude/direction command, then slews each mot_set toward it.
module mot_update_sched #(
  parameter int unsigned TICK_DIV = 50,
  parameter logic [15:0] ALT_STEP = 16'd4096,
  parameter logic [15:0] DIR_STEP = 16'd512,
  parameter logic [15:0] SLEW_MAX = 16'd64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       altcmd,
  input  logic [1:0][2:0]  dircmd,
  input  logic [3:0][15:0] rpm_sense,
  output logic [3:0][15:0] mot_set,
  output logic             busy,
  output logic [1:0]       mot_idx,
  output logic             upd_done
);

  // Wider than the nominal 18 bits so extreme parameter values cannot overflow.
  localparam int CW = 22;
  localparam logic [15:0] TC = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, CALC, UPD, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       alt_q, alt_d;
  logic [1:0][2:0]  dir_q, dir_d;
  logic [3:0][15:0] tgt_q, tgt_d;
  logic [3:0][15:0] mot_q, mot_d;
  logic [1:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic                 tick;
  logic signed [CW-1:0] base, p, r, dstep, d0_x, d1_x;
  logic signed [CW-1:0] tgt_x, rpm_x, err, step, slew, sum;

  function automatic logic [15:0] sat16(input logic signed [CW-1:0] v);
    if (v < 0)               return 16'd0;
    else if (v > 22'sd65535) return 16'hFFFF;
    else                     return v[15:0];
  endfunction

  assign tick = (cnt_q == TC) && enable;

  always_comb begin
    base  = $signed({3'b0, 19'(alt_q) * 19'(ALT_STEP)});
    dstep = $signed({6'b0, DIR_STEP});
    d0_x  = $signed({{19{dir_q[0][2]}}, dir_q[0]});
    d1_x  = $signed({{19{dir_q[1][2]}}, dir_q[1]});
    p     = d0_x * dstep;
    r     = d1_x * dstep;

    tgt_x = $signed({6'b0, tgt_q[idx_q]});
    rpm_x = $signed({{6{rpm_sense[idx_q][15]}}, rpm_sense[idx_q]});
    slew  = $signed({6'b0, SLEW_MAX});
    err   = tgt_x - rpm_x;
    if (err > slew)       step = slew;
    else if (err < -slew) step = -slew;
    else                  step = err;
    sum   = $signed({6'b0, mot_q[idx_q]}) + step;
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    alt_d   = alt_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    mot_d   = mot_q;
    idx_d   = idx_q;

    if (!enable)          cnt_d = 16'd0;
    else if (cnt_q == TC) cnt_d = 16'd0;
    else                  cnt_d = cnt_q + 16'd1;

    // ready_q mirrors state IDLE, so this is the acceptance handshake.
    if (cmd_valid && ready_q) begin
      alt_d = altcmd;
      dir_d = dircmd;
    end

    case (state_q)
      IDLE: if (tick) state_d = CALC;
      CALC: begin
        tgt_d[0] = sat16(base + p + r);
        tgt_d[1] = sat16(base + p - r);
        tgt_d[2] = sat16(base - p - r);
        tgt_d[3] = sat16(base - p + r);
        idx_d    = 2'd0;
        state_d  = UPD;
      end
      UPD: begin
        mot_d[idx_q] = sat16(sum);
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      alt_q   <= 3'd0;
      dir_q   <= '0;
      tgt_q   <= '0;
      mot_q   <= '0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alt_q   <= alt_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      mot_q   <= mot_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign mot_idx   = idx_q;
  assign upd_done  = done_q;
  assign mot_set   = mot_q;

endmodule

// File: tb/tb_mot_update_sched.sv
// Bench for mot_update_sched: directed scenarios plus randomized commands, all
// checked against an arithmetic model of the target/slew rules.
module tb_mot_update_sched;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       altcmd = '0;
  logic [1:0][2:0]  dircmd = '0;
  logic [3:0][15:0] rpm_sense = '0;
  logic [3:0][15:0] mot_set;
  logic             busy;
  logic [1:0]       mot_idx;
  logic             upd_done;

  int n_cmp = 0;
  int n_mis = 0;

  int m_set [4];
  int rpm_m [4];
  int m_alt, m_d0, m_d1;

  mot_update_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .altcmd(altcmd), .dircmd(dircmd),
    .rpm_sense(rpm_sense), .mot_set(mot_set), .busy(busy),
    .mot_idx(mot_idx), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int tgt_of(int i);
    int base, p, r, t;
    base = m_alt * 4096;
    p = m_d0 * 512;
    r = m_d1 * 512;
    case (i)
      0: t = base + p + r;
      1: t = base + p - r;
      2: t = base - p - r;
      default: t = base - p + r;
    endcase
    return clampi(t, 0, 65535);
  endfunction

  function automatic logic [3:0][15:0] exp_set();
    logic [3:0][15:0] e;
    for (int i = 0; i < 4; i++) e[i] = 16'(m_set[i]);
    return e;
  endfunction

  task automatic model_seq();
    for (int i = 0; i < 4; i++)
      m_set[i] = clampi(m_set[i] + clampi(tgt_of(i) - rpm_m[i], -64, 64), 0, 65535);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rpm();
    for (int i = 0; i < 4; i++) rpm_sense[i] = 16'(rpm_m[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_set[i] = 0;
    m_alt = 0; m_d0 = 0; m_d1 = 0;
  endtask

  task automatic send_cmd(input int alt, input int d0, input int d1, output bit ok);
    altcmd = 3'(alt);
    dircmd[0] = 3'(d0);
    dircmd[1] = 3'(d1);
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    step();
    cmd_valid = 1'b0;
    m_alt = alt; m_d0 = d0; m_d1 = d1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (upd_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idx(input logic [1:0] idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (busy === 1'b1 && mot_idx === idx) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int seen;
    enable = 1'b0;
    do_reset();
    n_cmp++;
    if (mot_set !== 64'd0) begin
      n_mis++; $display("FAIL reset_mot_set: got %h want 0", mot_set);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || mot_idx !== 2'd0 || upd_done !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: ready=%b busy=%b idx=%0d done=%b want 1 0 0 0",
               cmd_ready, busy, mot_idx, upd_done);
    end
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (upd_done !== 1'b0 || busy !== 1'b0 || mot_set !== 64'd0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_mis++; $display("FAIL disabled_idle: %0d active cycles, want 0", seen);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int first_busy, first_done;
    do_reset();
    for (int i = 0; i < 4; i++) rpm_m[i] = 0;
    drive_rpm();
    send_cmd(0, 3, -4, ok);
    enable = 1'b1;
    first_busy = -1; first_done = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (busy === 1'b1 && first_busy < 0) first_busy = c;
      if (upd_done === 1'b1 && first_done < 0) first_done = c;
      if (c == 52) begin
        n_cmp++;
        if (mot_set[1] !== 16'd0) begin
          n_mis++; $display("FAIL lat_m1_early: got %0d want 0", mot_set[1]);
        end
      end
      if (c == 53) begin
        n_cmp++;
        if (mot_set[1] !== 16'd64 || mot_set[2] !== 16'd0) begin
          n_mis++; $display("FAIL lat_m1: m1=%0d m2=%0d want 64 0", mot_set[1], mot_set[2]);
        end
      end
      if (c == 56) begin
        n_cmp++;
        if (upd_done !== 1'b0 || cmd_ready !== 1'b1) begin
          n_mis++; $display("FAIL lat_idle: done=%b ready=%b want 0 1", upd_done, cmd_ready);
        end
      end
    end
    n_cmp++;
    if (first_busy != 50 || first_done != 55) begin
      n_mis++;
      $display("FAIL lat_timing: busy@%0d done@%0d want 50 55", first_busy, first_done);
    end
    model_seq();
    n_cmp++;
    if (!ok || mot_set !== exp_set()) begin
      n_mis++; $display("FAIL dir_targets: got %h want %h", mot_set, exp_set());
    end
    enable = 1'b0;
  endtask

  task automatic test_integrator();
    bit ok, all_ok;
    do_reset();
    for (int i = 0; i < 4; i++) rpm_m[i] = 0;
    drive_rpm();
    send_cmd(2, 0, 0, ok);
    enable = 1'b1;
    all_ok = ok;
    for (int k = 1; k <= 129; k++) begin
      wait_done(ok);
      all_ok &= ok;
      model_seq();
      if (k == 1 || k == 128 || k == 129) begin
        n_cmp++;
        if (!all_ok || mot_set !== exp_set()) begin
          n_mis++;
          $display("FAIL integ_%0d: got %h want %h (ok=%b)", k, mot_set, exp_set(), all_ok);
        end
      end
    end
  endtask

  task automatic test_no_wrap();
    bit ok, all_ok;
    do_reset();
    for (int i = 0; i < 4; i++) rpm_m[i] = 0;
    drive_rpm();
    send_cmd(2, 0, 0, ok);
    all_ok = ok;
    enable = 1'b1;
    wait_done(ok); all_ok &= ok;
    model_seq();
    n_cmp++;
    if (!all_ok || mot_set !== exp_set()) begin
      n_mis++; $display("FAIL nowrap_pre: got %h want %h", mot_set, exp_set());
    end
    for (int i = 0; i < 4; i++) rpm_m[i] = 30000;
    drive_rpm();
    send_cmd(0, 0, 0, ok); all_ok &= ok;
    for (int k = 0; k < 2; k++) begin
      wait_done(ok); all_ok &= ok;
      model_seq();
      n_cmp++;
      if (!all_ok || mot_set !== exp_set()) begin
        n_mis++; $display("FAIL nowrap_%0d: got %h want %h", k, mot_set, exp_set());
      end
    end
  endtask

  task automatic test_busy_cmd();
    bit ok, all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) rpm_m[i] = 0;
    drive_rpm();
    // Command offered and withdrawn entirely inside a busy window must be ignored.
    wait_idx(2'd1, ok); all_ok &= ok;
    altcmd = 3'd7; cmd_valid = 1'b1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_mis++; $display("FAIL busy_ready_a: got %b want 0", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    wait_done(ok); all_ok &= ok;
    model_seq();
    wait_done(ok); all_ok &= ok;
    model_seq();
    n_cmp++;
    if (!all_ok || mot_set !== exp_set()) begin
      n_mis++; $display("FAIL busy_ignored: got %h want %h", mot_set, exp_set());
    end
    // Command held across busy is taken on the first IDLE cycle.
    wait_idx(2'd1, ok); all_ok &= ok;
    altcmd = 3'd5; dircmd = '0; cmd_valid = 1'b1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_mis++; $display("FAIL busy_ready_b: got %b want 0", cmd_ready);
    end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
    all_ok &= ok;
    step();
    cmd_valid = 1'b0;
    model_seq();
    m_alt = 5; m_d0 = 0; m_d1 = 0;
    for (int i = 0; i < 4; i++) rpm_m[i] = 20470;
    drive_rpm();
    wait_done(ok); all_ok &= ok;
    model_seq();
    n_cmp++;
    if (!all_ok || mot_set !== exp_set()) begin
      n_mis++; $display("FAIL busy_accept: got %h want %h", mot_set, exp_set());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    enable = 1'b1;
    wait_idx(2'd2, ok);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_set[i] = 0;
    m_alt = 0; m_d0 = 0; m_d1 = 0;
    n_cmp++;
    if (!ok || mot_set !== 64'd0 || busy !== 1'b0 || mot_idx !== 2'd0 || cmd_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_mid: ok=%b mot=%h busy=%b idx=%0d ready=%b want 0 0 0 1",
               ok, mot_set, busy, mot_idx, cmd_ready);
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (upd_done !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_mis++; $display("FAIL reset_mid_done: %0d pulses want 0", seen);
    end
  endtask

  task automatic test_random();
    bit ok, all_ok;
    int a, d0, d1;
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int it = 0; it < 24; it++) begin
      a  = int'($urandom_range(0, 7));
      d0 = int'($urandom_range(0, 7)) - 4;
      d1 = int'($urandom_range(0, 7)) - 4;
      m_alt = a; m_d0 = d0; m_d1 = d1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1)
          rpm_m[i] = tgt_of(i) - (int'($urandom_range(0, 300)) - 150);
        else
          rpm_m[i] = int'($urandom_range(0, 33767)) - 1000;
        rpm_m[i] = clampi(rpm_m[i], -32768, 32767);
      end
      drive_rpm();
      send_cmd(a, d0, d1, ok);
      all_ok = ok;
      wait_done(ok); all_ok &= ok;
      model_seq();
      n_cmp++;
      if (!all_ok || mot_set !== exp_set()) begin
        n_mis++;
        $display("FAIL random_%0d: alt=%0d d=%0d/%0d got %h want %h", it, a, d0, d1,
                 mot_set, exp_set());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_integrator();
    test_no_wrap();
    test_busy_cmd();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mot_update_sched.md
MOT_UPDATE_SCHED -- requirements
Module: mot_update_sched

Interface
REQ-001 Parameters: TICK_DIV, default 50, update period in clk cycles (legal range 8..65535); ALT_STEP, default 16'd4096, target rpm per altcmd unit; DIR_STEP, default 16'd512, offset per signed dircmd unit; SLEW_MAX, default 16'd64, max per-update mot_set change.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 enable  in  1  1 = periodic updates run; 0 = tick counter held at 0, no new update starts.
REQ-006 cmd_valid  in  1  altcmd/dircmd offered.
REQ-007 cmd_ready  out  1  high only in state IDLE.
REQ-008 altcmd  in  3  unsigned altitude command 0..7.
REQ-009 dircmd[1:0]  in  3 each  signed two's-complement: [0] pitch, [1] roll, range -4..3.
REQ-010 rpm_sense[3:0]  in  16 each  signed measured motor rpm.
REQ-011 mot_set[3:0]  out  16 each  unsigned motor setpoints, registered.
REQ-012 busy  out  1  high in CALC, UPD, DONE.
REQ-013 mot_idx  out  2  motor being updated; 0 outside UPD.
REQ-014 upd_done  out  1  one-cycle pulse at end of each update sequence.

Function
REQ-015 Command accepted on the cycle cmd_valid and cmd_ready are both 1; altcmd/dircmd latched into cmd registers; held until next acceptance.
REQ-016 Tick counter counts 0..TICK_DIV-1 while enable=1, wraps to 0; tick = (count == TICK_DIV-1) and enable.
REQ-017 FSM states IDLE, CALC, UPD, DONE; IDLE->CALC on tick; CALC->UPD after 1 cycle; UPD lasts 4 cycles with mot_idx 0,1,2,3; UPD->DONE after mot_idx 3; DONE->IDLE after 1 cycle with upd_done=1.
REQ-018 Tick counter keeps running during busy; TICK_DIV>=8 guarantees no tick arrives outside IDLE.
REQ-019 Command accepted in the same cycle as tick is used by that update.
REQ-020 CALC computes targets in 18-bit signed: base = altcmd*ALT_STEP, p = dircmd[0]*DIR_STEP, r = dircmd[1]*DIR_STEP; T0 = base+p+r, T1 = base+p-r, T2 = base-p-r, T3 = base-p+r; each saturated to 0..65535 and registered.
REQ-021 In UPD cycle i: err = Ti - rpm_sense[i] (18-bit signed, rpm_sense sampled that cycle); step = err clamped to [-SLEW_MAX, +SLEW_MAX]; mot_set[i] <= saturate(mot_set[i]+step, 0, 65535); no wrap-around.
REQ-022 Latency: tick in cycle T -> CALC T+1 -> mot_set[i] visible at T+3+i -> upd_done high in T+6 -> IDLE in T+7.
REQ-023 enable falling mid-sequence: current sequence completes; no further sequence starts while enable=0.
REQ-024 mot_set[j], j != mot_idx, holds value; all mot_set hold outside UPD.
REQ-025 cmd_valid while busy: not accepted, cmd registers unchanged; accepted first IDLE cycle if still asserted.

Reset
REQ-026 Reset (any state, incl. mid-UPD) next cycle: state IDLE, tick count 0, cmd registers 0, targets 0, mot_set all 0, mot_idx 0, busy 0, upd_done 0, cmd_ready 1.
REQ-027 Reset has priority over tick, command acceptance and enable.

Verification (defaults)
REQ-028 Reset then release, enable=0 -> mot_set all 0, cmd_ready 1, busy 0, no upd_done for 200 cycles.
REQ-029 enable=1, altcmd=2, dircmd=0/0, rpm_sense all 0 -> after first upd_done all mot_set=64; after 128 updates all 8192; 129th update leaves 8192+64 (integrator).
REQ-030 altcmd=0, dircmd[0]=3, dircmd[1]=3'b100, rpm_sense 0 -> targets 0,3584,512,0; after one update mot_set = 0,64,64,0; upd_done exactly 6 cycles after tick.
REQ-031 After one update at 64 each, rpm_sense=30000, altcmd=0 -> all mot_set 0; next update stays 0 (no wrap to 65472).
REQ-032 cmd_valid asserted during UPD with altcmd=5 -> cmd_ready 0, not accepted; accepted in first IDLE cycle; next update uses base 20480.
REQ-033 reset pulsed while mot_idx=2 -> next cycle all mot_set 0, busy 0, upd_done never pulses for that sequence.
